// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel compare timer.
// Channel mode encoding matches the ch_edge input bits.
package timer_pkg;
  localparam int CNT_W_DEF  = 64;
  localparam int NUM_CH_DEF = 4;
  localparam int DIV_MAX    = 8;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;
endpackage

// File: rtl/timer_cmp_ch.sv
// One compare channel: compare register, delayed match, sticky status and interrupt gate.
// A clear only loses to a fresh match rising; a held level match re-sets the cycle after a clear.
module timer_cmp_ch
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_wr_en,
  input  logic [CNT_W-1:0] i_wr_data,
  input  logic             i_ie,
  input  logic             i_edge,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cmp,
  output logic             o_st,
  output logic             o_int
);
  logic [CNT_W-1:0] r_cmp;
  logic             r_match_d;
  logic             r_st;
  logic             w_match;
  logic             w_rise;
  logic             w_set;

  assign w_match = (i_cnt == r_cmp);
  assign w_rise  = w_match & ~r_match_d;
  assign w_set   = (i_edge == MODE_EDGE) ? w_rise : w_match;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cmp     <= '1;
      r_match_d <= 1'b0;
      r_st      <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_cmp <= i_wr_data;
      end
      r_match_d <= w_match;
      if (i_clr && !w_rise) begin
        r_st <= 1'b0;
      end else if (w_set) begin
        r_st <= 1'b1;
      end
    end
  end

  assign o_cmp = r_cmp;
  assign o_st  = r_st;
  assign o_int = r_st & i_ie;
endmodule

// File: rtl/timer_mcmp_core.sv
// Free-running up-counter with 2^n prescaler, debug halt, overflow status
// and NUM_CH independent compare channels.
module timer_mcmp_core
  import timer_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    tmr_en,
  input  logic                    div_en,
  input  logic [DIV_W-1:0]        div_val,
  input  logic                    halt_req,
  output logic                    halt_ack,
  input  logic                    cnt_wr_en,
  input  logic [CNT_W-1:0]        cnt_wr_data,
  input  logic [NUM_CH-1:0]       cmp_wr_en,
  input  logic [CNT_W-1:0]        cmp_wr_data,
  input  logic [NUM_CH-1:0]       ch_ie,
  input  logic [NUM_CH-1:0]       ch_edge,
  input  logic [NUM_CH-1:0]       st_clr,
  input  logic                    ovf_ie,
  input  logic                    ovf_clr,
  output logic [CNT_W-1:0]        cnt_val,
  output logic [NUM_CH*CNT_W-1:0] cmp_val,
  output logic [NUM_CH-1:0]       int_st,
  output logic                    ovf_st,
  output logic [NUM_CH-1:0]       ch_int,
  output logic                    tim_int
);
  localparam int PRE_W = DIV_MAX;

  logic [CNT_W-1:0] r_cnt;
  logic [PRE_W-1:0] r_pre;
  logic [DIV_W-1:0] r_div_val_d;
  logic             r_halt;
  logic             r_ovf;

  logic [PRE_W-1:0] w_term;
  logic             w_div_ok;
  logic             w_div_chg;
  logic             w_pre_clr;
  logic             w_pre_hit;
  logic             w_tick;
  logic             w_wrap;

  // Terminal prescaler count 2^div_val - 1 as a thermometer mask.
  genvar gi;
  generate
    for (gi = 0; gi < PRE_W; gi++) begin : g_term
      assign w_term[gi] = (gi < int'(div_val));
    end
  endgenerate

  assign w_div_ok  = (int'(div_val) <= DIV_MAX);
  assign w_div_chg = (div_val != r_div_val_d);
  assign w_pre_clr = ~tmr_en | ~div_en | w_div_chg | cnt_wr_en;
  assign w_pre_hit = w_div_ok & ~w_div_chg & (r_pre == w_term);
  assign w_tick    = tmr_en & ~r_halt & (~div_en | w_pre_hit);
  assign w_wrap    = w_tick & ~cnt_wr_en & (r_cnt == '1);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pre       <= '0;
      r_div_val_d <= '0;
      r_halt      <= 1'b0;
    end else begin
      r_div_val_d <= div_val;
      r_halt      <= halt_req;
      if (w_pre_clr) begin
        r_pre <= '0;
      end else if (!r_halt && w_div_ok) begin
        r_pre <= (r_pre == w_term) ? '0 : r_pre + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (cnt_wr_en) begin
        r_cnt <= cnt_wr_data;
      end else if (w_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_wrap) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      timer_cmp_ch #(
        .CNT_W(CNT_W)
      ) u_ch (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .i_cnt    (r_cnt),
        .i_wr_en  (cmp_wr_en[gi]),
        .i_wr_data(cmp_wr_data),
        .i_ie     (ch_ie[gi]),
        .i_edge   (ch_edge[gi]),
        .i_clr    (st_clr[gi]),
        .o_cmp    (cmp_val[gi*CNT_W +: CNT_W]),
        .o_st     (int_st[gi]),
        .o_int    (ch_int[gi])
      );
    end
  endgenerate

  assign cnt_val  = r_cnt;
  assign ovf_st   = r_ovf;
  assign halt_ack = r_halt;
  assign tim_int  = (|ch_int) | (r_ovf & ovf_ie);
endmodule

// File: tb/tb_timer_mcmp_core.sv
// Directed bench for timer_mcmp_core: linear steps with hand-computed expectations.
module tb_timer_mcmp_core;
  localparam int CW = 64;
  localparam int NC = 4;
  localparam int DW = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              tmr_en, div_en, halt_req, halt_ack;
  logic [DW-1:0]     div_val;
  logic              cnt_wr_en;
  logic [CW-1:0]     cnt_wr_data, cmp_wr_data, cnt_val;
  logic [NC-1:0]     cmp_wr_en, ch_ie, ch_edge, st_clr, int_st, ch_int;
  logic              ovf_ie, ovf_clr, ovf_st, tim_int;
  logic [NC*CW-1:0]  cmp_val;

  int checks = 0;
  int failures = 0;

  timer_mcmp_core #(.CNT_W(CW), .NUM_CH(NC), .DIV_W(DW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tmr_en(tmr_en), .div_en(div_en),
    .div_val(div_val), .halt_req(halt_req), .halt_ack(halt_ack),
    .cnt_wr_en(cnt_wr_en), .cnt_wr_data(cnt_wr_data), .cmp_wr_en(cmp_wr_en),
    .cmp_wr_data(cmp_wr_data), .ch_ie(ch_ie), .ch_edge(ch_edge), .st_clr(st_clr),
    .ovf_ie(ovf_ie), .ovf_clr(ovf_clr), .cnt_val(cnt_val), .cmp_val(cmp_val),
    .int_st(int_st), .ovf_st(ovf_st), .ch_int(ch_int), .tim_int(tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst = 1'b1; tmr_en = 1'b0; div_en = 1'b0; div_val = '0; halt_req = 1'b0;
    cnt_wr_en = 1'b0; cnt_wr_data = '0; cmp_wr_en = '0; cmp_wr_data = '0;
    ch_ie = '0; ch_edge = '0; st_clr = '0; ovf_ie = 1'b0; ovf_clr = 1'b0;
    step(2);
    sys_rst = 1'b0;
    chk("rst_cnt", cnt_val, 64'h0);
    chk("rst_cmp0", cmp_val[0 +: CW], '1);
    chk("rst_cmp3", cmp_val[3*CW +: CW], '1);
    chk("rst_int_st", 64'(int_st), 64'h0);
    chk("rst_ovf", 64'(ovf_st), 64'h0);
    chk("rst_tim_int", 64'(tim_int), 64'h0);

    // Counter and level interrupt, halted on the match value.
    cnt_wr_en = 1'b1; cnt_wr_data = 64'hFC; cmp_wr_en = 4'b0001; cmp_wr_data = 64'hFF; ch_ie = 4'b0001;
    step;
    cnt_wr_en = 1'b0; cmp_wr_en = '0; tmr_en = 1'b1;
    step(2);
    chk("cnt_fe", cnt_val, 64'hFE);
    halt_req = 1'b1;
    step;
    chk("cnt_ff", cnt_val, 64'hFF);
    chk("halt_ack_1", 64'(halt_ack), 64'h1);
    chk("st0_pre", 64'(int_st[0]), 64'h0);
    chk("tint_pre", 64'(tim_int), 64'h0);
    step;
    chk("cnt_frozen", cnt_val, 64'hFF);
    chk("st0_set", 64'(int_st[0]), 64'h1);
    chk("tint_set", 64'(tim_int), 64'h1);
    step;
    chk("st0_noclr", 64'(int_st[0]), 64'h1);
    st_clr = 4'b0001;
    step;
    st_clr = '0;
    chk("st0_clr", 64'(int_st[0]), 64'h0);
    chk("tint_clr", 64'(tim_int), 64'h0);
    step;
    chk("st0_reset", 64'(int_st[0]), 64'h1);
    chk("tint_reset", 64'(tim_int), 64'h1);
    halt_req = 1'b0;
    step;
    chk("halt_ack_0", 64'(halt_ack), 64'h0);
    chk("cnt_still_ff", cnt_val, 64'hFF);
    step;
    chk("cnt_100", cnt_val, 64'h100);
    st_clr = 4'b0001;
    step;
    st_clr = '0;
    chk("st0_cleared", 64'(int_st[0]), 64'h0);

    // Enable gating.
    tmr_en = 1'b0; ch_ie = '0;
    cnt_wr_en = 1'b1; cnt_wr_data = 64'h1FE; cmp_wr_en = 4'b0001; cmp_wr_data = 64'h1FF;
    step;
    cnt_wr_en = 1'b0; cmp_wr_en = '0; tmr_en = 1'b1;
    step;
    tmr_en = 1'b0;
    step;
    chk("gate_st0", 64'(int_st[0]), 64'h1);
    chk("gate_tint0", 64'(tim_int), 64'h0);
    ch_ie = 4'b0001;
    #1;
    chk("gate_tint1", 64'(tim_int), 64'h1);
    chk("gate_chint", 64'(ch_int), 64'h1);
    cmp_wr_en = 4'b0001; cmp_wr_data = '1;
    step;
    cmp_wr_en = '0; st_clr = 4'b0001;
    step;
    st_clr = '0; ch_ie = '0;
    chk("gate_cleanup", 64'(int_st), 64'h0);

    // Static equality, level then edge mode on channel 1.
    cnt_wr_en = 1'b1; cnt_wr_data = 64'h123; cmp_wr_en = 4'b0010; cmp_wr_data = 64'h123;
    step;
    cnt_wr_en = 1'b0; cmp_wr_en = '0;
    step;
    chk("lvl_set", 64'(int_st[1]), 64'h1);
    st_clr = 4'b0010;
    step;
    st_clr = '0;
    chk("lvl_clr", 64'(int_st[1]), 64'h0);
    step;
    chk("lvl_reset", 64'(int_st[1]), 64'h1);
    ch_edge = 4'b0010; st_clr = 4'b0010;
    step;
    st_clr = '0;
    chk("edg_clr", 64'(int_st[1]), 64'h0);
    step;
    chk("edg_hold0", 64'(int_st[1]), 64'h0);
    cmp_wr_en = 4'b0010; cmp_wr_data = 64'h0;
    step;
    cmp_wr_data = 64'h123;
    step;
    cmp_wr_en = '0;
    step;
    chk("edg_set", 64'(int_st[1]), 64'h1);
    st_clr = 4'b0010;
    step;
    st_clr = '0;
    chk("edg_clr2", 64'(int_st[1]), 64'h0);
    step;
    chk("edg_stay0", 64'(int_st[1]), 64'h0);
    cmp_wr_en = 4'b0010; cmp_wr_data = '1; ch_edge = '0;
    step;
    cmp_wr_en = '0; st_clr = 4'b0010;
    step;
    st_clr = '0;
    chk("eq_cleanup", 64'(int_st), 64'h0);

    // Prescaler divide by 4, phase restart, out-of-range select.
    cnt_wr_en = 1'b1; cnt_wr_data = 64'h0; div_en = 1'b1; div_val = 4'd2; tmr_en = 1'b1;
    step;
    cnt_wr_en = 1'b0;
    step(3);
    chk("pre_3cyc", cnt_val, 64'h0);
    step;
    chk("pre_4cyc", cnt_val, 64'h1);
    step(4);
    chk("pre_8cyc", cnt_val, 64'h2);
    step(2);
    div_val = 4'd3;
    step;
    chk("pre_chg", cnt_val, 64'h2);
    step(7);
    chk("pre_7of8", cnt_val, 64'h2);
    step;
    chk("pre_8of8", cnt_val, 64'h3);
    div_val = 4'd9;
    step(21);
    chk("pre_div9", cnt_val, 64'h3);
    div_en = 1'b0; tmr_en = 1'b0; div_val = '0;

    // Overflow with clear on the wrap cycle; channel 2 matches zero.
    cnt_wr_en = 1'b1; cnt_wr_data = '1; cmp_wr_en = 4'b0100; cmp_wr_data = 64'h0;
    step;
    cnt_wr_en = 1'b0; cmp_wr_en = '0; tmr_en = 1'b1; ovf_clr = 1'b1;
    step;
    ovf_clr = 1'b0; tmr_en = 1'b0;
    chk("ovf_cnt0", cnt_val, 64'h0);
    chk("ovf_setwins", 64'(ovf_st), 64'h1);
    chk("ovf_st2_pre", 64'(int_st[2]), 64'h0);
    step;
    chk("ovf_st2_set", 64'(int_st[2]), 64'h1);
    ovf_ie = 1'b1;
    #1;
    chk("ovf_tint", 64'(tim_int), 64'h1);
    ovf_clr = 1'b1;
    step;
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(ovf_st), 64'h0);
    chk("ovf_tint0", 64'(tim_int), 64'h0);

    // Halt mid-count, then reset mid-count.
    cnt_wr_en = 1'b1; cnt_wr_data = 64'h10; tmr_en = 1'b1;
    step;
    cnt_wr_en = 1'b0; halt_req = 1'b1;
    step;
    chk("halt_cnt11", cnt_val, 64'h11);
    chk("halt_ack", 64'(halt_ack), 64'h1);
    step(2);
    chk("halt_frozen", cnt_val, 64'h11);
    halt_req = 1'b0;
    step;
    chk("halt_rel", cnt_val, 64'h11);
    step;
    chk("halt_resume", cnt_val, 64'h12);
    ch_ie = '1;
    #1;
    chk("pre_rst_tint", 64'(tim_int), 64'h1);
    halt_req = 1'b1; sys_rst = 1'b1;
    step;
    chk("rst2_cnt", cnt_val, 64'h0);
    chk("rst2_int_st", 64'(int_st), 64'h0);
    chk("rst2_ovf", 64'(ovf_st), 64'h0);
    chk("rst2_halt", 64'(halt_ack), 64'h0);
    chk("rst2_cmp2", cmp_val[2*CW +: CW], '1);
    chk("rst2_tint", 64'(tim_int), 64'h0);
    sys_rst = 1'b0; halt_req = 1'b0; tmr_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
